// File: rtl/mpe_window_sequencer.sv
// Captures one input tile and streams strided windows for each kernel position.
// Optional zero padding is enabled by defining MPE_SEQ_PAD_EN.
module mpe_window_sequencer #(
  parameter int BIN_LEN    = 16,
  parameter int IN_H       = 8,
  parameter int IN_W       = 8,
  parameter int OUT_H      = 4,
  parameter int OUT_W      = 4,
  parameter int K_H        = 3,
  parameter int K_W        = 3,
  parameter int STRIDE_MAX = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BIN_LEN*IN_H*IN_W-1:0]      in_vals,
  input  logic [$clog2(K_H+1)-1:0]          cfg_kh_len,
  input  logic [$clog2(K_W+1)-1:0]          cfg_kw_len,
  input  logic [2:0]                        cfg_stride,
  input  logic [1:0]                        cfg_pad,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BIN_LEN*OUT_H*OUT_W-1:0]    out_vals,
  output logic [$clog2(K_H)-1:0]            out_kh,
  output logic [$clog2(K_W)-1:0]            out_kw,
  output logic                              out_last,
  output logic                              done
);

  localparam int KHL = $clog2(K_H+1);
  localparam int KWL = $clog2(K_W+1);
  localparam int KHW = $clog2(K_H);
  localparam int KWW = $clog2(K_W);
  localparam int TW  = BIN_LEN*IN_H*IN_W;
  localparam int OW  = BIN_LEN*OUT_H*OUT_W;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      tile_q, tile_d;
  logic [KHL-1:0]     kh_len_q, kh_len_d;
  logic [KWL-1:0]     kw_len_q, kw_len_d;
  logic [2:0]         stride_q, stride_d;
  logic [1:0]         pad_q, pad_d;
  logic [KHW-1:0]     kh_q, kh_d;
  logic [KWW-1:0]     kw_q, kw_d;
  logic [OW-1:0]      out_vals_q, out_vals_d;
  logic               done_q, done_d;
  logic               kh_at_last, kw_at_last;

  assign kh_at_last = (kh_q == KHW'(kh_len_q - 1'b1));
  assign kw_at_last = (kw_q == KWW'(kw_len_q - 1'b1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      tile_q     <= '0;
      kh_len_q   <= '0;
      kw_len_q   <= '0;
      stride_q   <= '0;
      pad_q      <= '0;
      kh_q       <= '0;
      kw_q       <= '0;
      out_vals_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tile_q     <= tile_d;
      kh_len_q   <= kh_len_d;
      kw_len_q   <= kw_len_d;
      stride_q   <= stride_d;
      pad_q      <= pad_d;
      kh_q       <= kh_d;
      kw_q       <= kw_d;
      out_vals_q <= out_vals_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tile_d   = tile_q;
    kh_len_d = kh_len_q;
    kw_len_d = kw_len_q;
    stride_d = stride_q;
    pad_d    = pad_q;
    kh_d     = kh_q;
    kw_d     = kw_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          tile_d  = in_vals;
          kh_d    = '0;
          kw_d    = '0;
`ifdef MPE_SEQ_PAD_EN
          pad_d   = cfg_pad;
`endif
          // Sanitise lengths and stride so the sweep is always well formed
          if (cfg_kh_len == '0)             kh_len_d = KHL'(1);
          else if (cfg_kh_len > KHL'(K_H))  kh_len_d = KHL'(K_H);
          else                              kh_len_d = cfg_kh_len;
          if (cfg_kw_len == '0)             kw_len_d = KWL'(1);
          else if (cfg_kw_len > KWL'(K_W))  kw_len_d = KWL'(K_W);
          else                              kw_len_d = cfg_kw_len;
          if (cfg_stride == 3'd0)                  stride_d = 3'd1;
          else if (cfg_stride > 3'(STRIDE_MAX))    stride_d = 3'(STRIDE_MAX);
          else                                     stride_d = cfg_stride;
        end
      end
      RUN: begin
        if (out_ready) begin
          if (kw_at_last) begin
            kw_d = '0;
            if (kh_at_last) begin
              state_d = IDLE;
              done_d  = 1'b1;
              kh_d    = '0;
            end else begin
              kh_d = kh_q + 1'b1;
            end
          end else begin
            kw_d = kw_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window for the next position, so out_vals is purely registered
  always_comb begin
    int r;
    int c;
    r = 0;
    c = 0;
    out_vals_d = '0;
    for (int i = 0; i < OUT_H; i++) begin
      for (int j = 0; j < OUT_W; j++) begin
        r = i*int'(stride_d) + int'(kh_d);
        c = j*int'(stride_d) + int'(kw_d);
`ifdef MPE_SEQ_PAD_EN
        r = r - int'(pad_d);
        c = c - int'(pad_d);
`endif
        if (r >= 0 && r < IN_H && c >= 0 && c < IN_W)
          out_vals_d[(i*OUT_W+j)*BIN_LEN +: BIN_LEN] =
            tile_d[(r*IN_W+c)*BIN_LEN +: BIN_LEN];
      end
    end
  end

`ifndef MPE_SEQ_PAD_EN
  logic [1:0] unused_pad;
  assign unused_pad = cfg_pad;
`endif

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == RUN);
    out_last  = (state_q == RUN) && kh_at_last && kw_at_last;
    done      = done_q;
  end

  assign out_vals = out_vals_q;
  assign out_kh   = kh_q;
  assign out_kw   = kw_q;

endmodule

// File: tb/tb_mpe_window_sequencer.sv
// Directed bench for mpe_window_sequencer with hand-computed window values.
module tb_mpe_window_sequencer;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1023:0] in_vals;
  logic [1:0]   cfg_kh_len;
  logic [1:0]   cfg_kw_len;
  logic [2:0]   cfg_stride;
  logic [1:0]   cfg_pad;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_vals;
  logic [1:0]   out_kh;
  logic [1:0]   out_kw;
  logic         out_last;
  logic         done;

  int total = 0;
  int pass  = 0;
  int pad_tb = 0;

  mpe_window_sequencer dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_vals(in_vals),
    .cfg_kh_len(cfg_kh_len), .cfg_kw_len(cfg_kw_len),
    .cfg_stride(cfg_stride), .cfg_pad(cfg_pad),
    .out_valid(out_valid), .out_ready(out_ready), .out_vals(out_vals),
    .out_kh(out_kh), .out_kw(out_kw), .out_last(out_last), .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] oel(input int i, input int j);
    return out_vals[(i*4+j)*16 +: 16];
  endfunction

  function automatic logic [15:0] model(input int i, j, kh, kw, s);
    int r;
    int c;
    r = i*s + kh - pad_tb;
    c = j*s + kw - pad_tb;
    if (r < 0 || r >= 8 || c < 0 || c >= 8) return 16'h0;
    return 16'(r*16 + c);
  endfunction

  task automatic load(input int khl, kwl, s, p);
    in_valid   = 1'b1;
    cfg_kh_len = 2'(khl);
    cfg_kw_len = 2'(kwl);
    cfg_stride = 3'(s);
    cfg_pad    = 2'(p);
    @(negedge clock);
    in_valid   = 1'b0;
  endtask

  // ek/es: effective sanitised lengths and stride
  task automatic sweep(input string nm, input int khl, kwl, s,
                       input int hk, hw, i1, j1, input logic [15:0] v1,
                       input int i2, j2, input logic [15:0] v2);
    logic el;
    for (int kh = 0; kh < khl; kh++) begin
      for (int kw = 0; kw < kwl; kw++) begin
        el = (kh == khl-1) && (kw == kwl-1);
        total++;
        if (out_valid !== 1'b1 || out_kh !== 2'(kh) || out_kw !== 2'(kw) ||
            out_last !== el)
          $display("FAIL %s pos: got v=%b kh=%0d kw=%0d last=%b want kh=%0d kw=%0d last=%b",
                   nm, out_valid, out_kh, out_kw, out_last, kh, kw, el);
        else pass++;
        total++;
        if (oel(1, 2) !== model(1, 2, kh, kw, s))
          $display("FAIL %s elem12 (%0d,%0d): got %h want %h",
                   nm, kh, kw, oel(1, 2), model(1, 2, kh, kw, s));
        else pass++;
        if (kh == hk && kw == hw) begin
          total++;
          if (oel(i1, j1) !== v1)
            $display("FAIL %s hand1: got %h want %h", nm, oel(i1, j1), v1);
          else pass++;
          total++;
          if (oel(i2, j2) !== v2)
            $display("FAIL %s hand2: got %h want %h", nm, oel(i2, j2), v2);
          else pass++;
        end
        @(negedge clock);
      end
    end
    total++;
    if (done !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL %s end: got done=%b rdy=%b v=%b want 1 1 0",
               nm, done, in_ready, out_valid);
    else pass++;
  endtask

  task automatic test_reset;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        done !== 1'b0 || out_vals !== '0 || out_kh !== 2'd0 || out_kw !== 2'd0)
      $display("FAIL reset: got rdy=%b v=%b last=%b done=%b kh=%0d kw=%0d",
               in_ready, out_valid, out_last, done, out_kh, out_kw);
    else pass++;
  endtask

  task automatic test_stride1;
    load(3, 3, 1, 0);
    sweep("s1k3", 3, 3, 1, 1, 2, 0, 0, 16'h12, 3, 3, 16'h45);
    @(negedge clock);
    total++;
    if (done !== 1'b0) $display("FAIL done_pulse: got %b want 0", done);
    else pass++;
  endtask

  task automatic test_back_to_back;
    load(2, 2, 2, 0);
    sweep("s2k2", 2, 2, 2, 1, 1, 3, 3, 16'h77, 0, 0, 16'h11);
    load(3, 3, 2, 0);
    sweep("s2k3", 3, 3, 2, 2, 2, 3, 3, 16'h00, 2, 2, 16'h66);
  endtask

  task automatic test_sanitise;
    load(0, 0, 0, 0);
    sweep("zero", 1, 1, 1, 0, 0, 3, 3, 16'h33, 1, 2, 16'h12);
    load(2, 1, 7, 0);
    sweep("s7", 2, 1, 2, 1, 0, 3, 3, 16'h76, 1, 1, 16'h32);
  endtask

  task automatic test_backpressure;
    logic [255:0] held;
    load(3, 3, 1, 0);
    for (int b = 0; b < 9; b++) begin
      total++;
      if (out_valid !== 1'b1 || out_kh !== 2'(b/3) || out_kw !== 2'(b%3))
        $display("FAIL bp_seq %0d: got kh=%0d kw=%0d want %0d %0d",
                 b, out_kh, out_kw, b/3, b%3);
      else pass++;
      if (b == 3) begin
        held = out_vals;
        total++;
        if (oel(0, 0) !== 16'h10)
          $display("FAIL bp_val: got %h want 0010", oel(0, 0));
        else pass++;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clock);
          total++;
          if (out_vals !== held || out_kh !== 2'd1 || out_kw !== 2'd0 ||
              out_valid !== 1'b1 || out_last !== 1'b0)
            $display("FAIL bp_hold %0d: got kh=%0d kw=%0d v=%b", k,
                     out_kh, out_kw, out_valid);
          else pass++;
        end
        out_ready = 1'b1;
      end
      @(negedge clock);
    end
    total++;
    if (done !== 1'b1) $display("FAIL bp_done: got %b want 1", done);
    else pass++;
  endtask

  task automatic test_mid_reset;
    load(3, 3, 1, 0);
    repeat (4) @(negedge clock);
    total++;
    if (out_kh !== 2'd1 || out_kw !== 2'd1)
      $display("FAIL rst_pos: got kh=%0d kw=%0d want 1 1", out_kh, out_kw);
    else pass++;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_vals !== '0 || in_ready !== 1'b1 ||
        out_kh !== 2'd0 || out_kw !== 2'd0 || done !== 1'b0)
      $display("FAIL rst_mid: got v=%b rdy=%b kh=%0d kw=%0d done=%b",
               out_valid, in_ready, out_kh, out_kw, done);
    else pass++;
    load(2, 2, 1, 0);
    sweep("rst_reload", 2, 2, 1, 0, 0, 3, 3, 16'h33, 1, 1, 16'h11);
  endtask

`ifdef MPE_SEQ_PAD_EN
  task automatic test_pad;
    pad_tb = 1;
    load(2, 2, 1, 1);
    total++;
    if (oel(0, 2) !== 16'h0 || oel(2, 0) !== 16'h0 || oel(1, 1) !== 16'h00 ||
        oel(1, 2) !== 16'h01 || oel(3, 3) !== 16'h22)
      $display("FAIL pad00: got %h %h %h %h %h want 0 0 0 1 22", oel(0, 2),
               oel(2, 0), oel(1, 1), oel(1, 2), oel(3, 3));
    else pass++;
    sweep("pad", 2, 2, 1, 1, 1, 1, 1, 16'h11, 0, 0, 16'h00);
    pad_tb = 0;
  endtask
`endif

  initial begin
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        in_vals[(r*8+c)*16 +: 16] = 16'(r*16 + c);
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cfg_kh_len = 2'd0;
    cfg_kw_len = 2'd0;
    cfg_stride = 3'd0;
    cfg_pad = 2'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    test_reset();
    test_stride1();
    test_back_to_back();
    test_sanitise();
    test_backpressure();
    test_mid_reset();
`ifdef MPE_SEQ_PAD_EN
    test_pad();
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
